// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace symbols (1-3 per cycle) into 15-symbol frames for the OCI data-trace path.
// Optional idle auto-flush is compiled in with `define DCT_IDLE_FLUSH_EN.
module nios2_oci_dct_packer #(
    parameter int CNT_W       = 16,
    parameter int IDLE_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_num,
    input  logic [5:0]       in_sym,
    input  logic             flush,
    input  logic             stop,
    output logic             dct_valid,
    input  logic             dct_ready,
    output logic [29:0]      dct_buffer,
    output logic [3:0]       dct_count,
    output logic             test_ending,
    output logic             test_has_ended,
    output logic [CNT_W-1:0] frames_out
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ENDED = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [29:0]      acc_reg, acc_next;
    logic [3:0]       acc_cnt_reg, acc_cnt_next;
    logic             flush_pend_reg, flush_pend_next;
    logic             dct_valid_reg;
    logic [29:0]      dct_buffer_reg;
    logic [3:0]       dct_count_reg;
    logic [CNT_W-1:0] frames_out_reg;

    logic        slot_free;
    logic [1:0]  take;
    logic [4:0]  sum;
    logic [5:0]  sym_mask;
    logic [35:0] merged;
    logic        idle_flush;
    logic        flush_req;
    logic        stop_req;
    logic        fl;
    logic        emit;
    logic [29:0] emit_buf;
    logic [3:0]  emit_cnt;

    assign slot_free = ~dct_valid_reg | dct_ready;
    assign in_ready  = slot_free & (state_reg == ST_RUN);
    assign take      = (in_valid & in_ready) ? in_num : 2'd0;
    assign sum       = {1'b0, acc_cnt_reg} + {3'b000, take};

    always_comb begin
        sym_mask = 6'h00;
        case (take)
            2'd1:    sym_mask = 6'h03;
            2'd2:    sym_mask = 6'h0F;
            2'd3:    sym_mask = 6'h3F;
            default: sym_mask = 6'h00;
        endcase
    end

    // Accumulator bits above acc_cnt are always zero, so OR-merging is enough.
    assign merged = {6'b0, acc_reg} | ({30'b0, in_sym & sym_mask} << {acc_cnt_reg, 1'b0});

    assign flush_req = (flush | idle_flush) & (state_reg != ST_ENDED);
    assign stop_req  = stop & (state_reg == ST_RUN);
    assign fl        = flush_req | flush_pend_reg;

    always_comb begin
        acc_next        = acc_reg;
        acc_cnt_next    = acc_cnt_reg;
        flush_pend_next = flush_pend_reg | (flush_req & ~slot_free);
        emit            = 1'b0;
        emit_buf        = merged[29:0];
        emit_cnt        = 4'd15;
        if (sum >= 5'd15) begin
            // Full frame; the overflow symbols restart the accumulator at bit 0.
            emit            = 1'b1;
            acc_next        = {24'b0, merged[35:30]};
            acc_cnt_next    = 4'(sum - 5'd15);
            flush_pend_next = fl & (sum != 5'd15);
        end else if (fl & slot_free & (sum != 5'd0)) begin
            emit            = 1'b1;
            emit_cnt        = sum[3:0];
            acc_next        = 30'b0;
            acc_cnt_next    = 4'd0;
            flush_pend_next = 1'b0;
        end else begin
            acc_next     = merged[29:0];
            acc_cnt_next = sum[3:0];
            if (fl & (sum == 5'd0)) begin
                flush_pend_next = 1'b0;
            end
        end
        if (stop_req) begin
            flush_pend_next = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (stop_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((acc_cnt_reg == 4'd0) & ~flush_pend_reg & ~dct_valid_reg) begin
                    state_next = ST_ENDED;
                end
            end
            ST_ENDED: state_next = ST_ENDED;
            default:  state_next = ST_RUN;
        endcase
    end

`ifdef DCT_IDLE_FLUSH_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    logic [IW-1:0] idle_cnt_reg, idle_cnt_next;
    logic          idle_hit;

    // Fires on the cycle the counter would reach IDLE_CYCLES.
    assign idle_hit   = (acc_cnt_reg != 4'd0) & (take == 2'd0) &
                        (idle_cnt_reg == IW'(IDLE_CYCLES - 1));
    assign idle_flush = idle_hit;

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if ((take != 2'd0) | emit | idle_hit) begin
            idle_cnt_next = '0;
        end else if (acc_cnt_reg != 4'd0) begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`else
    // Idle flush compiled out; the parameter only keeps the interface stable.
    assign idle_flush = 1'b0 & (IDLE_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_RUN;
            acc_reg        <= 30'b0;
            acc_cnt_reg    <= 4'd0;
            flush_pend_reg <= 1'b0;
            dct_valid_reg  <= 1'b0;
            dct_buffer_reg <= 30'b0;
            dct_count_reg  <= 4'd0;
            frames_out_reg <= '0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            acc_cnt_reg    <= acc_cnt_next;
            flush_pend_reg <= flush_pend_next;
            if (emit) begin
                dct_valid_reg  <= 1'b1;
                dct_buffer_reg <= emit_buf;
                dct_count_reg  <= emit_cnt;
            end else if (dct_ready) begin
                dct_valid_reg <= 1'b0;
            end
            if (dct_valid_reg & dct_ready) begin
                frames_out_reg <= frames_out_reg + 1'b1;
            end
        end
    end

    assign dct_valid      = dct_valid_reg;
    assign dct_buffer     = dct_buffer_reg;
    assign dct_count      = dct_count_reg;
    assign frames_out     = frames_out_reg;
    assign test_ending    = (state_reg != ST_RUN);
    assign test_has_ended = (state_reg == ST_ENDED);

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed bench for nios2_oci_dct_packer; honours `define DCT_IDLE_FLUSH_EN for the idle test.
module tb_nios2_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_num;
    logic [5:0]  in_sym;
    logic        flush;
    logic        stop;
    logic        dct_valid;
    logic        dct_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic [15:0] frames_out;

    int errors = 0;
    int checks = 0;

    nios2_oci_dct_packer #(.CNT_W(16), .IDLE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_sym(in_sym),
        .flush(flush), .stop(stop),
        .dct_valid(dct_valid), .dct_ready(dct_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .frames_out(frames_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && dct_valid && dct_ready)
            $display("frame delivered: count=%0d buffer=%h frames_out=%0d", dct_count, dct_buffer, frames_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] n, input logic [5:0] s);
        in_valid = 1'b1;
        in_num   = n;
        in_sym   = s;
        $display("send: num=%0d sym=%b", n, s);
        tick();
        in_valid = 1'b0;
        in_num   = 2'd0;
        in_sym   = 6'd0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dct_valid); end
        checks++; if (dct_buffer !== 30'h0) begin errors++; $display("FAIL reset_buffer: got %h want 0", dct_buffer); end
        checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dct_count); end
        checks++; if ({test_ending, test_has_ended} !== 2'b00) begin errors++; $display("FAIL reset_test_flags: got %b want 00", {test_ending, test_has_ended}); end
        checks++; if (frames_out !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames_out); end
        tick();
        reset_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full_frame();
        dct_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(2'd3, 6'b111001);
        checks++; if (dct_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", dct_valid); end
        checks++; if (dct_count !== 4'd15) begin errors++; $display("FAIL full_count: got %0d want 15", dct_count); end
        checks++; if (dct_buffer !== 30'h39E79E79) begin errors++; $display("FAIL full_buffer: got %h want 39e79e79", dct_buffer); end
        tick();
        checks++; if (frames_out !== 16'd1) begin errors++; $display("FAIL full_frames: got %0d want 1", frames_out); end
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL full_valid_drop: got %b want 0", dct_valid); end
    endtask

    task automatic test_overflow();
        dct_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd3, 6'b111001);
        send(2'd2, 6'b000110);
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_early_frame: got %b want 0", dct_valid); end
        send(2'd3, 6'b011011);
        checks++; if (dct_count !== 4'd15) begin errors++; $display("FAIL ovf_count: got %0d want 15", dct_count); end
        checks++; if (dct_buffer !== 30'h36E79E79) begin errors++; $display("FAIL ovf_buffer: got %h want 36e79e79", dct_buffer); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_flush_pending();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b1; in_num = 2'd3; in_sym = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fp_in_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
            checks++; if (dct_buffer !== 30'h36E79E79) begin errors++; $display("FAIL fp_hold[%0d]: got %h want 36e79e79", i, dct_buffer); end
        end
        in_valid = 1'b0; in_num = 2'd0; in_sym = 6'd0;
        dct_ready = 1'b1;
        tick();
        checks++; if (dct_valid !== 1'b1) begin errors++; $display("FAIL fp_valid: got %b want 1", dct_valid); end
        checks++; if (dct_count !== 4'd2) begin errors++; $display("FAIL fp_count: got %0d want 2", dct_count); end
        checks++; if (dct_buffer !== 30'h6) begin errors++; $display("FAIL fp_buffer: got %h want 6", dct_buffer); end
        checks++; if (frames_out !== 16'd2) begin errors++; $display("FAIL fp_frames: got %0d want 2", frames_out); end
        tick();
        checks++; if (frames_out !== 16'd3) begin errors++; $display("FAIL fp_frames2: got %0d want 3", frames_out); end
    endtask

    task automatic test_stop();
        send(2'd3, 6'b111001);
        send(2'd3, 6'b111001);
        send(2'd1, 6'b000001);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (test_ending !== 1'b1) begin errors++; $display("FAIL stop_ending: got %b want 1", test_ending); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stop_in_ready: got %b want 0", in_ready); end
        checks++; if (test_has_ended !== 1'b0) begin errors++; $display("FAIL stop_early_end: got %b want 0", test_has_ended); end
        tick();
        checks++; if (dct_valid !== 1'b1) begin errors++; $display("FAIL stop_valid: got %b want 1", dct_valid); end
        checks++; if (dct_count !== 4'd7) begin errors++; $display("FAIL stop_count: got %0d want 7", dct_count); end
        checks++; if (dct_buffer !== 30'h1E79) begin errors++; $display("FAIL stop_buffer: got %h want 1e79", dct_buffer); end
        for (int i = 0; i < 10 && test_has_ended !== 1'b1; i++) tick();
        checks++; if (test_has_ended !== 1'b1) begin errors++; $display("FAIL stop_ended_timeout: got %b want 1", test_has_ended); end
        checks++; if (frames_out !== 16'd4) begin errors++; $display("FAIL stop_frames: got %0d want 4", frames_out); end
        stop = 1'b1; flush = 1'b1; in_valid = 1'b1; in_num = 2'd3; in_sym = 6'b101010;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ended_in_ready: got %b want 0", in_ready); end
        tick();
        stop = 1'b0; flush = 1'b0; in_valid = 1'b0; in_num = 2'd0; in_sym = 6'd0;
        tick(); tick();
        checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL ended_no_frame: got %b want 0", dct_valid); end
        checks++; if ({test_ending, test_has_ended} !== 2'b11) begin errors++; $display("FAIL ended_sticky: got %b want 11", {test_ending, test_has_ended}); end
        checks++; if (frames_out !== 16'd4) begin errors++; $display("FAIL ended_frames: got %0d want 4", frames_out); end
    endtask

    task automatic test_mid_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        dct_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd3, 6'b111001);
        send(2'd2, 6'b000110);
        send(2'd3, 6'b011011);
        checks++; if (dct_valid !== 1'b1) begin errors++; $display("FAIL mr_pre_valid: got %b want 1", dct_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({dct_valid, dct_count, test_ending, test_has_ended} !== 7'b0) begin errors++; $display("FAIL mr_async_outputs: got %b want 0", {dct_valid, dct_count, test_ending, test_has_ended}); end
        checks++; if (dct_buffer !== 30'h0) begin errors++; $display("FAIL mr_async_buffer: got %h want 0", dct_buffer); end
        checks++; if (frames_out !== 16'd0) begin errors++; $display("FAIL mr_async_frames: got %0d want 0", frames_out); end
        tick();
        reset_n = 1'b1;
        dct_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL mr_stale_frame[%0d]: got %b want 0", i, dct_valid); end
            tick();
        end
        checks++; if (frames_out !== 16'd0) begin errors++; $display("FAIL mr_frames: got %0d want 0", frames_out); end
    endtask

    task automatic test_idle();
        int          first;
        logic [3:0]  cnt_seen;
        logic [29:0] buf_seen;
        first = 0; cnt_seen = 4'd0; buf_seen = 30'h0;
        dct_ready = 1'b1;
        send(2'd2, 6'b001011);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (dct_valid === 1'b1 && first == 0) begin
                first = k; cnt_seen = dct_count; buf_seen = dct_buffer;
            end
        end
`ifdef DCT_IDLE_FLUSH_EN
        checks++; if (first != 4) begin errors++; $display("FAIL idle_latency: got %0d want 4", first); end
        checks++; if (cnt_seen !== 4'd2) begin errors++; $display("FAIL idle_count: got %0d want 2", cnt_seen); end
        checks++; if (buf_seen !== 30'hB) begin errors++; $display("FAIL idle_buffer: got %h want b", buf_seen); end
`else
        checks++; if (first != 0) begin errors++; $display("FAIL idle_no_autoflush: frame at cycle %0d want none", first); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (dct_count !== 4'd2) begin errors++; $display("FAIL idle_flush_count: got %0d want 2", dct_count); end
        checks++; if (dct_buffer !== 30'hB) begin errors++; $display("FAIL idle_flush_buffer: got %h want b", dct_buffer); end
`endif
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_num = 2'd0; in_sym = 6'd0;
        flush = 1'b0; stop = 1'b0; dct_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_overflow();
        test_flush_pending();
        test_stop();
        test_mid_reset();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
